// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared NTT types, constants and lane-packing helper
`include "ntt_params.svh"

package ntt_pkg;

    localparam int NTT_K     = `K;
    localparam int MAX_LANES = 16;

    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} modop_e;

    // Lane i of a packed multi-lane vector; narrower buses are zero-extended by the caller.
    function automatic logic [NTT_K-1:0] lane(input logic [MAX_LANES*NTT_K-1:0] vec, input int i);
        return vec[i*NTT_K +: NTT_K];
    endfunction

endpackage

// File: rtl/mod_addsub_lane.sv
// rtl/mod_addsub_lane.sv - single-lane final modular reduction of a (K+1)-bit sum/difference
`include "ntt_params.svh"

module mod_addsub_lane
    import ntt_pkg::*;
#(
    parameter int K = `K
) (
    input  logic [K:0]   s,
    input  logic [K-1:0] mod,
    input  modop_e       op,
    output logic [K-1:0] result
);

    logic [K:0] diff;
    logic [K:0] wrap;

    // diff[K] set means s < mod, i.e. the sum already lies in [0, mod).
    assign diff = s - {1'b0, mod};
    assign wrap = s + {1'b0, mod};

    always_comb begin
        result = s[K-1:0];
        if (op == OP_ADD) begin
            if (!diff[K]) begin
                result = diff[K-1:0];
            end
        end else if (s[K]) begin
            result = wrap[K-1:0];
        end
    end

endmodule

// File: rtl/ntt_params.svh
// rtl/ntt_params.svh - project-wide NTT datapath parameters
`ifndef NTT_PARAMS_SVH
`define NTT_PARAMS_SVH

`define K 12

`endif

// File: rtl/mod_addsub_pipe.sv
// rtl/mod_addsub_pipe.sv - two-stage multi-lane modular add/sub with valid/ready flow control
`include "ntt_params.svh"

module mod_addsub_pipe
    import ntt_pkg::*;
#(
    parameter int K     = `K,
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mod_load,
    input  logic [K-1:0]         mod_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_op,
    input  logic [LANES*K-1:0]   in_a,
    input  logic [LANES*K-1:0]   in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*K-1:0]   out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [1:0]           inflight
);

    logic [K-1:0]             mod_reg;

    logic                     s1_valid;
    modop_e                   s1_op;
    logic [TAG_W-1:0]         s1_tag;
    logic [K-1:0]             s1_mod;
    logic [LANES*(K+1)-1:0]   s1_sum;

    logic [LANES*(K+1)-1:0]   sum_next;
    logic [LANES*K-1:0]       reduced;

    logic                     s2_adv;
    logic                     s1_adv;
    logic                     accept;
    logic                     s1_valid_next;
    logic                     out_valid_next;

    // Bubble-collapsing ready chain; in_ready never depends on in_valid.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    assign accept   = in_valid && s1_adv;

    assign s1_valid_next  = s1_adv ? in_valid : s1_valid;
    assign out_valid_next = s2_adv ? s1_valid : out_valid;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [K-1:0] a;
            logic [K-1:0] b;

            assign a = in_a[i*K +: K];
            assign b = in_b[i*K +: K];
            assign sum_next[i*(K+1) +: K+1] = (in_op == OP_SUB) ? ({1'b0, a} - {1'b0, b})
                                                                : ({1'b0, a} + {1'b0, b});

            mod_addsub_lane #(
                .K (K)
            ) u_lane (
                .s      (s1_sum[i*(K+1) +: K+1]),
                .mod    (s1_mod),
                .op     (s1_op),
                .result (reduced[i*K +: K])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mod_reg    <= '0;
            s1_valid   <= 1'b0;
            s1_op      <= OP_ADD;
            s1_tag     <= '0;
            s1_mod     <= '0;
            s1_sum     <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            inflight   <= 2'd0;
        end else begin
            if (mod_load) begin
                mod_reg <= mod_in;
            end

            // A beat accepted on a load edge still sees the old mod_reg here.
            if (s1_adv) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_op  <= modop_e'(in_op);
                s1_tag <= in_tag;
                s1_mod <= mod_reg;
                s1_sum <= sum_next;
            end

            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= reduced;
                    out_tag    <= s1_tag;
                end
            end

            inflight <= {1'b0, s1_valid_next} + {1'b0, out_valid_next};
        end
    end

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// tb/tb_mod_addsub_pipe.sv - self-checking scoreboard bench for mod_addsub_pipe
module tb_mod_addsub_pipe;
    import ntt_pkg::*;

    localparam int K  = NTT_K;
    localparam int L  = 4;
    localparam int TW = 8;

    typedef struct {
        logic [L*K-1:0] res;
        logic [TW-1:0]  tag;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mod_load = 1'b0;
    logic [K-1:0]      mod_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_op = 1'b0;
    logic [L*K-1:0]    in_a = '0;
    logic [L*K-1:0]    in_b = '0;
    logic [TW-1:0]     in_tag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [L*K-1:0]    out_result;
    logic [TW-1:0]     out_tag;
    logic [1:0]        inflight;

    int     tests = 0;
    int     fails = 0;
    int     cur_mod = 0;
    int     last_wait = 0;
    int     out_cnt = 0;
    logic   rand_ready = 1'b0;
    exp_t   sb[$];
    exp_t   mon_e;
    logic   held = 1'b0;
    logic [L*K-1:0] held_res;
    logic [TW-1:0]  held_tag;

    mod_addsub_pipe #(
        .K     (K),
        .LANES (L),
        .TAG_W (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mod_load   (mod_load),
        .mod_in     (mod_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [L*K-1:0] pk(input int v0, input int v1, input int v2, input int v3);
        return {v3[K-1:0], v2[K-1:0], v1[K-1:0], v0[K-1:0]};
    endfunction

    function automatic logic [L*K-1:0] model(input logic op, input logic [L*K-1:0] a,
                                             input logic [L*K-1:0] b, input int m);
        logic [MAX_LANES*K-1:0] ae;
        logic [MAX_LANES*K-1:0] be;
        logic [L*K-1:0] res;
        int x, y, r;
        ae  = (MAX_LANES*K)'(a);
        be  = (MAX_LANES*K)'(b);
        res = '0;
        for (int i = 0; i < L; i++) begin
            x = int'(lane(ae, i));
            y = int'(lane(be, i));
            r = op ? (x - y + m) % m : (x + y) % m;
            res[i*K +: K] = r[K-1:0];
        end
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic load_mod(input int v);
        mod_load = 1'b1;
        mod_in   = v[K-1:0];
        step();
        mod_load = 1'b0;
        cur_mod  = v;
    endtask

    task automatic send(input logic op, input logic [L*K-1:0] a, input logic [L*K-1:0] b,
                        input logic [TW-1:0] tag, input logic ld, input int ldv);
        int   waited;
        logic accepted;
        exp_t e;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        mod_load = ld;
        mod_in   = ldv[K-1:0];
        waited   = 0;
        accepted = 1'b0;
        while (!accepted && waited < 200) begin
            @(negedge clk);
            if (in_ready) begin
                e.res = model(op, a, b, cur_mod);
                e.tag = tag;
                sb.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!accepted) waited++;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        mod_load = 1'b0;
        if (ld && accepted) cur_mod = ldv;
        last_wait = waited;
        chk("accept_in_time", 64'(accepted), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            step();
            n++;
        end
        chk("drain_scoreboard_empty", 64'(sb.size()), 64'd0);
    endtask

    function automatic int rnd_op(input int m);
        if ($urandom_range(0, 3) == 0) return m - 1;
        return int'($urandom_range(0, m - 1));
    endfunction

    // Output monitor: pops the scoreboard on each handshake and checks stall stability.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_result", 64'(out_result), 64'(held_res));
                chk("hold_tag", 64'(out_tag), 64'(held_tag));
            end
            held     = out_valid && !out_ready;
            held_res = out_result;
            held_tag = out_tag;
            if (out_valid && out_ready) begin
                chk("beat_was_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("result", 64'(out_result), 64'(mon_e.res));
                    chk("tag_order", 64'(out_tag), 64'(mon_e.tag));
                    out_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [L*K-1:0] a;
        logic [L*K-1:0] b;
        logic           op;
        int             c0, m;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_result", 64'(out_result), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_mod_reg", 64'(dut.mod_reg), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        load_mod(17);
        send(1'b0, pk(9, 16, 0, 8), pk(12, 16, 0, 8), 8'hA1, 1'b0, 0);
        chk("t1_only_s1", 64'(out_valid), 64'd0);
        chk("t1_inflight1", 64'(inflight), 64'd1);
        step();
        chk("t1_latency", 64'(out_valid), 64'd1);
        chk("t1_add_lanes", 64'(out_result), 64'(pk(4, 15, 0, 16)));
        chk("t1_tag", 64'(out_tag), 64'hA1);

        send(1'b1, pk(3, 5, 0, 16), pk(5, 3, 16, 16), 8'hB2, 1'b0, 0);
        step();
        chk("t2_sub_lanes", 64'(out_result), 64'(pk(15, 2, 1, 0)));

        step();
        c0 = out_cnt;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < L; i++) begin
                a[i*K +: K] = K'($urandom_range(0, 16));
                b[i*K +: K] = K'($urandom_range(0, 16));
            end
            send(1'(k % 2), a, b, TW'(8'h10 + k), 1'b0, 0);
            chk("t3_no_backpressure", 64'(last_wait), 64'd0);
        end
        chk("t3_no_bubbles", 64'(out_cnt - c0), 64'd8);
        chk("t3_out_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b0;
        #1;
        chk("t3_in_ready_drop", 64'(in_ready), 64'd0);
        chk("t3_inflight2", 64'(inflight), 64'd2);
        repeat (3) step();
        drain();

        send(1'b0, pk(10, 10, 10, 10), pk(10, 10, 10, 10), 8'hC4, 1'b1, 97);
        send(1'b0, pk(90, 20, 50, 96), pk(20, 90, 46, 1), 8'hC5, 1'b0, 0);
        chk("t4_old_mod", 64'(out_result), 64'(pk(3, 3, 3, 3)));
        chk("t4_mod_reg", 64'(dut.mod_reg), 64'd97);
        step();
        chk("t4_new_mod", 64'(out_result), 64'(pk(13, 13, 96, 0)));
        drain();

        out_ready = 1'b0;
        send(1'b0, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 8'hD1, 1'b0, 0);
        send(1'b1, pk(1, 2, 3, 4), pk(5, 6, 7, 8), 8'hD2, 1'b0, 0);
        chk("t5_inflight2", 64'(inflight), 64'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_async_out_valid", 64'(out_valid), 64'd0);
        chk("t5_async_inflight", 64'(inflight), 64'd0);
        chk("t5_async_mod_reg", 64'(dut.mod_reg), 64'd0);
        sb.delete();
        cur_mod = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        repeat (4) step();
        chk("t5_no_stale", 64'(out_valid), 64'd0);

        for (int r = 0; r < 4; r++) begin
            m = (r == 0) ? (1 << K) - 1 : int'($urandom_range(2, (1 << K) - 1));
            load_mod(m);
            rand_ready = 1'b1;
            for (int k = 0; k < 30; k++) begin
                op = 1'($urandom_range(0, 1));
                for (int i = 0; i < L; i++) begin
                    a[i*K +: K] = K'(rnd_op(m));
                    b[i*K +: K] = K'(rnd_op(m));
                end
                send(op, a, b, TW'(r * 40 + k), 1'b0, 0);
            end
        end
        drain();
        chk("t6_out_idle", 64'(out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mod_addsub_pipe.md
Name: mod_addsub_pipe

Overview:
Multi-lane pipelined modular adder/subtractor with valid/ready flow control, for the NTT butterfly and pointwise stages. Each accepted beat carries LANES operand pairs, one op select (add or sub) and a tag. Results are reduced into [0, mod). The modulus is a runtime register, and its value is captured per beat, so the modulus can be reloaded while beats are in flight.

Parameters:
K, `K (project params header), operand/modulus width in bits
LANES, 4, independent lanes per beat, all sharing op and modulus
TAG_W, 8, width of the sideband tag carried alongside each beat

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mod_load  in  1  pulse; mod_reg <= mod_in on this edge
mod_in  in  K  new modulus, nonzero, < 2^K
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_op  in  1  0 = add (a+b mod m), 1 = sub (a-b mod m)
in_a  in  LANES*K  operand a, lane i at [i*K +: K]
in_b  in  LANES*K  operand b, same packing
in_tag  in  TAG_W  sideband, returned unchanged with the result
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts when out_valid && out_ready
out_result  out  LANES*K  reduced results, same packing
out_tag  out  TAG_W  tag of this beat
inflight  out  2  number of beats held in stages S1 and S2 (0..2)

Behaviour:
- Reset state: all stage valids 0, out_valid 0, out_result 0, out_tag 0, mod_reg 0, inflight 0. in_ready is 1 once rst deasserts. Asserting rst mid-operation drops every in-flight beat with no output.
- Precondition per lane: a < mod and b < mod, where mod is the value of mod_reg on the accept cycle. The behaviour for out-of-range operands is undefined and is not checked.
- Modulus capture:
  - mod_reg updates on any edge with mod_load=1.
  - A beat accepted on the same edge uses the OLD mod_reg.
  - The accepted beat copies mod_reg into S1; that copy travels with the beat to S2.
  - A later mod_load never affects beats already accepted.
- Stage S1 (accept edge), each lane, (K+1)-bit:
  - add: s = a + b
  - sub: s = {1'b0,a} - {1'b0,b}; bit K set means negative
  - Registered with op, tag and the captured mod.
- Stage S2 (output register), each lane:
  - add: r = s - mod; result = r[K] ? s[K-1:0] : r[K-1:0]
  - sub: result = s[K] ? (s + mod)[K-1:0] : s[K-1:0]
- Latency: a beat accepted at edge n appears with out_valid=1 after edge n+1. This holds with no stall, i.e. 2 registers.
- Full throughput: one beat per cycle when out_ready is held at 1.
- Flow control uses per-stage bubble-collapsing ready:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no combinational path from in_valid)
- S2 loads from S1 when s2_adv. If s2_adv is 1 and s1_valid is 0, out_valid goes 0 on that edge.
- A stalled stage holds data, tag and mod stable. out_result and out_tag must not change while out_valid && !out_ready.
- Simultaneous events: accept into S1 and S1→S2 transfer on the same edge are legal.
- inflight: s1_valid + out_valid, registered.
- No overflow is possible: (K+1)-bit intermediates cover a+b ≤ 2m-2 < 2^(K+1).

Decomposition:
- ntt_pkg holds:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} modop_e
  - a lane-packing helper function lane(vec, i)
- K stays in the params header.
- One sub-module, mod_addsub_lane: a combinational S2 reduction for a single lane (inputs s[K:0], mod, op; output result[K-1:0]), instantiated LANES times via generate.
- The pipeline registers and handshake stay in mod_addsub_pipe.

Test Plan:
1. mod_load 17. Lane0 add 9+12, lane1 add 16+16, lane2 add 0+0, lane3 add 8+8. out_ready=1 → after 2 edges out_result lanes = 4, 15, 0, 16; out_tag echoed.
2. mod 17, sub lanes (3-5, 5-3, 0-16, 16-16) → 15, 2, 1, 0.
3. Streaming: 10 back-to-back beats with out_ready=1 → in_ready stays 1, outputs in order with 2-cycle latency and no bubbles. Then out_ready=0 for 3 cycles → in_ready drops after 2 beats buffered, inflight=2, out_result stable. Release → no loss or duplication.
4. mod_load 97 on the same edge as a beat (add 20+90) while mod_reg=17 → that beat uses 17: result (110 mod 17)? Precondition violated, so use add 10+10 instead → 3. The next beat (add 90+20 under 97) → 13.
5. rst asserted while inflight=2 → out_valid 0 and inflight 0 immediately (async), mod_reg 0. After release, in_ready=1 and no stale beat ever appears.
6. Randomised check at K=`K, LANES=4, max modulus 2^K-1, against a reference model: operands m-1 for both add and sub, mixed ops, random out_ready → all results match (a±b) mod m and tags preserve order.
